// File: rtl/pio_master_pkg.sv
// Shared types and PIO register addresses for the push-button Avalon-MM initiator.
package pio_master_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_CMP     = 3'd4
  } pio_state_t;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;

endpackage

// File: rtl/pio_button_master_evt_fifo.sv
// Synchronous event queue; a push while full is taken only when a pop frees the head slot in the same cycle.
module evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/pio_button_master.sv
// Avalon-MM initiator polling the button PIO and queueing newly pressed bits as events.
// Define PIO_IRQ_TRIGGER_EN to program the PIO irq mask at startup and poll immediately on irq_in.
//
// state      | meaning
// ST_INIT    | startup; irq-mask write when the irq feature is built in
// ST_IDLE    | waiting for a pending poll (or irq)
// ST_RD_REQ  | read of the data register presented, held through waitrequest
// ST_RD_WAIT | counting read latency, then capturing the sample
// ST_CMP     | edge detect against the previous sample, push event
module pio_button_master
  import pio_master_pkg::*;
#(
  parameter int          DATA_W       = 4,
  parameter int          POLL_DIV     = 50000,
  parameter int          READ_LATENCY = 1,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] MASK_INIT    = 32'h0000_000F
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              irq_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_data,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int TMR_W = $clog2(POLL_DIV);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  pio_state_t        r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [LAT_W-1:0]  r_lat;
  logic [DATA_W-1:0] r_sample, r_prev, w_rise;
  logic              r_pending, r_primed, r_read, r_overflow;
  logic              w_tick, w_irq_hit, w_enter_rd, w_push, w_pop, w_full, w_empty, w_unused;

  assign w_tick     = (r_timer == TMR_W'(POLL_DIV - 1));
  assign w_enter_rd = (r_state == ST_IDLE) && (w_state_nxt == ST_RD_REQ);
  assign w_rise     = r_sample & ~r_prev;
  assign w_push     = (r_state == ST_CMP) && r_primed && (|w_rise);
  assign w_pop      = evt_valid & evt_ready;

`ifdef PIO_IRQ_TRIGGER_EN
  logic        r_write;
  logic [1:0]  r_addr;
  logic [31:0] r_wdata;

  assign w_irq_hit     = irq_in;
  assign avm_write     = r_write;
  assign avm_address   = r_addr;
  assign avm_writedata = r_wdata;
  assign w_unused      = ^avm_readdata[31:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_write <= (w_state_nxt == ST_INIT);
      r_addr  <= (w_state_nxt == ST_INIT) ? PIO_ADDR_IRQMASK : PIO_ADDR_DATA;
      r_wdata <= (w_state_nxt == ST_INIT) ? MASK_INIT : 32'd0;
    end
  end
`else
  assign w_irq_hit     = 1'b0;
  assign avm_write     = 1'b0;
  assign avm_address   = PIO_ADDR_DATA;
  assign avm_writedata = 32'd0;
  assign w_unused      = ^{irq_in, MASK_INIT, PIO_ADDR_IRQMASK, avm_readdata[31:DATA_W]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef PIO_IRQ_TRIGGER_EN
      ST_INIT:    if (r_write && !avm_waitrequest) w_state_nxt = ST_IDLE;
`else
      ST_INIT:    w_state_nxt = ST_IDLE;
`endif
      ST_IDLE:    if (r_pending || w_irq_hit) w_state_nxt = ST_RD_REQ;
      ST_RD_REQ:  if (!avm_waitrequest) w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (r_lat == '0) w_state_nxt = ST_CMP;
      ST_CMP:     w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_INIT;
      r_read    <= 1'b0;
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_lat     <= '0;
      r_sample  <= '0;
      r_prev    <= '0;
      r_primed  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_read  <= (w_state_nxt == ST_RD_REQ);
      r_timer <= w_tick ? '0 : r_timer + TMR_W'(1);
      // A tick coinciding with the start of a read is kept, giving one follow-up poll.
      r_pending <= w_tick | (r_pending & ~w_enter_rd);
      if (r_state == ST_RD_REQ && !avm_waitrequest) r_lat <= LAT_W'(READ_LATENCY - 1);
      else if (r_state == ST_RD_WAIT && r_lat != '0) r_lat <= r_lat - LAT_W'(1);
      if (r_state == ST_RD_WAIT && r_lat == '0) r_sample <= avm_readdata[DATA_W-1:0];
      if (r_state == ST_CMP) begin
        r_prev   <= r_sample;
        r_primed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_overflow <= 1'b0;
    else if (clr_overflow) r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
  end

  assign avm_read  = r_read;
  assign overflow  = r_overflow;
  assign evt_valid = ~w_empty;

  evt_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_rise),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (evt_data)
  );

endmodule

// File: tb/tb_pio_button_master.sv
// Directed bench for pio_button_master with a behavioural PIO responder (POLL_DIV=10, READ_LATENCY=2).
module tb_pio_button_master;

  localparam int DATA_W   = 4;
  localparam int POLL_DIV = 10;
  localparam int RD_LAT   = 2;
  localparam int DEPTH    = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;
  logic        irq_in;
  logic        evt_valid, evt_ready;
  logic [3:0]  evt_data;
  logic        overflow, clr_overflow;

  logic [3:0]  buttons;
  int          rsp_cnt = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          t_first, t_second, t_dummy;
  logic [3:0]  presses [9];
  logic [3:0]  drain   [8];

  pio_button_master #(
    .DATA_W       (DATA_W),
    .POLL_DIV     (POLL_DIV),
    .READ_LATENCY (RD_LAT),
    .FIFO_DEPTH   (DEPTH),
    .MASK_INIT    (32'h0000_000F)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .irq_in          (irq_in),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_data        (evt_data),
    .overflow        (overflow),
    .clr_overflow    (clr_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: button value is on readdata only in the cycle before the sampling edge; garbage otherwise.
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) rsp_cnt <= RD_LAT;
    else if (rsp_cnt != 0) rsp_cnt <= rsp_cnt - 1;
  end
  always_comb avm_readdata = (rsp_cnt == 1) ? {28'h0, buttons} : {28'hABCDEF1, ~buttons};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_read(output int at);
    logic found = 1'b0;
    at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (avm_read) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    check("read_timeout", {31'd0, found}, 32'd1);
  endtask

  // One full poll; optionally pops the head in the same cycle the event is pushed.
  task automatic poll(input logic [3:0] v, input bit pop_at_push, output int at);
    buttons = v;
    wait_read(at);
    if (pop_at_push) begin
      repeat (3) @(negedge clk);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    presses = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b1111};
    drain   = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0101};
    reset_n = 1'b0;
    avm_waitrequest = 1'b0;
    irq_in = 1'b0;
    evt_ready = 1'b0;
    clr_overflow = 1'b0;
    buttons = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_write", {31'd0, avm_write}, 32'd0);
    check("rst_addr", {30'd0, avm_address}, 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_evt_data", {28'd0, evt_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;

`ifdef PIO_IRQ_TRIGGER_EN
    @(negedge clk);
    check("init_write", {31'd0, avm_write}, 32'd1);
    check("init_addr", {30'd0, avm_address}, 32'd2);
    check("init_wdata", avm_writedata, 32'h0000_000F);
    check("init_no_read", {31'd0, avm_read}, 32'd0);
    @(negedge clk);
    check("init_write_done", {31'd0, avm_write}, 32'd0);
`endif

    // priming poll, then a press before the second poll
    poll(4'b0000, 1'b0, t_first);
    check("prime_no_evt", {31'd0, evt_valid}, 32'd0);
    check("no_write", {31'd0, avm_write}, 32'd0);
    poll(4'b0101, 1'b0, t_second);
    check("poll_spacing", t_second - t_first, 32'd10);
    check("press_valid", {31'd0, evt_valid}, 32'd1);
    check("press_data", {28'd0, evt_data}, 32'b0101);
    pop_one();
    check("pop_empty", {31'd0, evt_valid}, 32'd0);

    // held buttons, one new bit, then release
    poll(4'b0101, 1'b0, t_dummy);
    check("held_no_evt", {31'd0, evt_valid}, 32'd0);
    poll(4'b0111, 1'b0, t_dummy);
    check("rise_valid", {31'd0, evt_valid}, 32'd1);
    check("rise_data", {28'd0, evt_data}, 32'b0010);
    pop_one();
    poll(4'b0000, 1'b0, t_dummy);
    check("release_no_evt", {31'd0, evt_valid}, 32'd0);

    // stalled read: request held 4 cycles, early readdata ignored
    buttons = 4'b1000;
    avm_waitrequest = 1'b1;
    wait_read(t_dummy);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_read", {31'd0, avm_read}, 32'd1);
      check("stall_addr", {30'd0, avm_address}, 32'd0);
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check("read_dropped", {31'd0, avm_read}, 32'd0);
    repeat (3) @(negedge clk);
    check("stall_evt_valid", {31'd0, evt_valid}, 32'd1);
    check("stall_evt_data", {28'd0, evt_data}, 32'b1000);
    pop_one();

`ifdef PIO_IRQ_TRIGGER_EN
    irq_in = 1'b1;
    @(negedge clk);
    check("irq_read", {31'd0, avm_read}, 32'd1);
    irq_in = 1'b0;
    repeat (4) @(negedge clk);
`endif

    // fill the queue past its depth with no consumer
    for (int i = 0; i < 9; i++) begin
      poll(presses[i], 1'b0, t_dummy);
      if (i == 7) check("full_no_ovf", {31'd0, overflow}, 32'd0);
      poll(4'b0000, 1'b0, t_dummy);
    end
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_head", {28'd0, evt_data}, 32'b0001);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_clr", {31'd0, overflow}, 32'd0);
    poll(4'b0101, 1'b1, t_dummy);
    check("push_pop_full_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", {31'd0, evt_valid}, 32'd1);
      check("drain_data", {28'd0, evt_data}, {28'd0, drain[i]});
      pop_one();
    end
    check("drain_empty", {31'd0, evt_valid}, 32'd0);

    // reset in the middle of a stalled read
    poll(4'b0000, 1'b0, t_dummy);
    poll(4'b0010, 1'b0, t_dummy);
    check("pre_rst_evt", {31'd0, evt_valid}, 32'd1);
    buttons = 4'b0101;
    avm_waitrequest = 1'b1;
    wait_read(t_dummy);
    reset_n = 1'b0;
    #1;
    check("rst_abort_read", {31'd0, avm_read}, 32'd0);
    check("rst_fifo_empty", {31'd0, evt_valid}, 32'd0);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
`ifdef PIO_IRQ_TRIGGER_EN
    @(negedge clk);
    check("restart_init_write", {31'd0, avm_write}, 32'd1);
`endif
    poll(4'b0101, 1'b0, t_dummy);
    check("reprime_no_evt", {31'd0, evt_valid}, 32'd0);
    poll(4'b1101, 1'b0, t_dummy);
    check("after_reprime_data", {28'd0, evt_data}, 32'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
